// File: rtl/imm_ext_unit_if.sv
// Bus bundle for imm_ext_unit: instruction-side inputs and the registered ID/EX outputs.
interface imm_ext_unit_if #(
  parameter int unsigned IMM_W  = 6,
  parameter int unsigned PFX_W  = 10,
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic              pfx;
  logic [PFX_W-1:0]  pfx_in;
  logic [IMM_W-1:0]  imm_in;
  logic [1:0]        mode;
  logic [DATA_W-1:0] imm_out;
  logic              out_valid;
  logic              pfx_pending;

  modport master (
    output in_valid, stall, flush, pfx, pfx_in, imm_in, mode,
    input  imm_out, out_valid, pfx_pending
  );

  modport slave (
    input  in_valid, stall, flush, pfx, pfx_in, imm_in, mode,
    output imm_out, out_valid, pfx_pending
  );
endinterface

// File: rtl/imm_ext_unit.sv
// Registered immediate extender with stall/flush for the ID/EX boundary.
// Prefix-instruction support (upper immediate bits) is built only when IMM_EXT_PFX_EN is defined.
module imm_ext_unit #(
  parameter int unsigned IMM_W  = 6,
  parameter int unsigned PFX_W  = 10,
  parameter int unsigned DATA_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  imm_ext_unit_if.slave bus
);
  localparam int unsigned ShIdle = DATA_W - IMM_W;

  logic [DATA_W-1:0] w_fz;   // field zero-extended to DATA_W
  logic [DATA_W-1:0] w_up;   // field placed at the top of the word
  logic [DATA_W-1:0] w_sx;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] r_imm_out;
  logic              r_out_valid;

`ifdef IMM_EXT_PFX_EN
  localparam int unsigned ShPfx = DATA_W - PFX_W - IMM_W;

  typedef enum logic [0:0] {StIdle, StPrefixed} state_e;
  state_e           r_state;
  logic [PFX_W-1:0] r_pfx;

  always_comb begin
    w_fz = '0;
    w_up = '0;
    w_sx = '0;
    if (r_state == StPrefixed) begin
      w_fz = DATA_W'({r_pfx, bus.imm_in});
      w_up = w_fz << ShPfx;
      w_sx = $unsigned($signed(w_up) >>> ShPfx);
    end else begin
      w_fz = DATA_W'(bus.imm_in);
      w_up = w_fz << ShIdle;
      w_sx = $unsigned($signed(w_up) >>> ShIdle);
    end
  end
`else
  logic unused_pfx;
  assign unused_pfx = ^{bus.pfx, bus.pfx_in};

  always_comb begin
    w_fz = DATA_W'(bus.imm_in);
    w_up = w_fz << ShIdle;
    w_sx = $unsigned($signed(w_up) >>> ShIdle);
  end
`endif

  always_comb begin
    w_ext = '0;
    case (bus.mode)
      2'b00:   w_ext = w_sx;
      2'b01:   w_ext = w_fz;
      2'b10:   w_ext = w_fz >> 1;
      default: w_ext = w_up;
    endcase
  end

`ifdef IMM_EXT_PFX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pfx       <= '0;
      r_imm_out   <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= StIdle;
      r_pfx       <= '0;
      r_out_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (!bus.in_valid) begin
        r_out_valid <= 1'b0;
      end else if (bus.pfx) begin
        r_pfx       <= bus.pfx_in;
        r_state     <= StPrefixed;
        r_out_valid <= 1'b0;
      end else begin
        r_imm_out   <= w_ext;
        r_out_valid <= 1'b1;
        r_state     <= StIdle;
      end
    end
  end

  assign bus.pfx_pending = (r_state == StPrefixed);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm_out   <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        r_imm_out   <= w_ext;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.pfx_pending = 1'b0;
`endif

  assign bus.imm_out   = r_imm_out;
  assign bus.out_valid = r_out_valid;
endmodule
